// File: rtl/nibble_serial_add_if.sv
// Handshake and adder-side bundle for the nibble-serial add sequencer.
// The slave side is the sequencer; the master side is the producer/consumer plus the 4-bit adder.
interface nibble_serial_add_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [4:0]   add_s;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_s,
    input  in_ready, out_valid, out_sum, add_a, add_b, add_cin
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_s,
    output in_ready, out_valid, out_sum, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial sequencer around an external combinational 4-bit adder:
// one nibble pair per cycle, LSB first, carry kept in a register between nibbles.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | one nibble per cycle through the external adder
// DONE  | result presented until downstream accepts it
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  nibble_serial_add_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  a_reg, b_reg;
  logic [W:0]    sum_reg;
  logic          last;

  assign last        = (cnt == CW'(NIBBLES - 1));
  assign bus.out_sum = sum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = 4'h0;
    bus.add_b     = 4'h0;
    bus.add_cin   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        bus.add_a   = a_reg[4*cnt +: 4];
        bus.add_b   = b_reg[4*cnt +: 4];
        bus.add_cin = carry;
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are captured only at acceptance, so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        a_reg <= bus.in_a;
        b_reg <= bus.in_b;
        carry <= bus.in_cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        sum_reg[4*cnt +: 4] <= bus.add_s[3:0];
        carry               <= bus.add_s[4];
        cnt                 <= cnt + CW'(1);
        if (last) sum_reg[W] <= bus.add_s[4];
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: a 4-nibble instance and a 1-nibble
// instance, each closed around a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_serial_add_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_add_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus4.add_s = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {4'h0, bus4.add_cin};
  assign bus1.add_s = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'h0, bus1.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation on the 4-nibble instance with out_ready high.
  // lat = rising edges from acceptance until out_valid (-1 on timeout);
  // cin_ones = RUN cycles in which add_cin was 1.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [16:0] sum, output int lat, output int cin_ones);
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.in_a      = a;
    bus4.in_b      = b;
    bus4.in_cin    = cin;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    bus4.in_a     = ~a;
    bus4.in_b     = a ^ 16'h5A5A;
    bus4.in_cin   = ~cin;
    lat      = -1;
    cin_ones = 0;
    sum      = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus4.out_valid) begin
        lat = i;
        sum = bus4.out_sum;
        break;
      end
      if (bus4.add_cin) cin_ones++;
    end
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_a      = '0;
    bus4.in_b      = '0;
    bus4.in_cin    = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_cin    = 1'b0;
    bus1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus4.in_ready); end
    checks++;
    if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus4.out_valid); end
    checks++;
    if (bus4.out_sum !== 17'h0) begin errors++; $display("FAIL reset_out_sum got %h want 00000", bus4.out_sum); end
    checks++;
    if ({bus4.add_a, bus4.add_b, bus4.add_cin} !== 9'h0) begin
      errors++; $display("FAIL reset_adder_inputs got %h want 000", {bus4.add_a, bus4.add_b, bus4.add_cin});
    end
  endtask

  task automatic test_arith();
    logic [16:0] sum;
    int lat, ones;
    do_op(16'h1234, 16'h4321, 1'b0, sum, lat, ones);
    checks++;
    if (sum !== 17'h05555) begin errors++; $display("FAIL v1_sum got %h want 05555", sum); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL v1_latency got %0d want 4", lat); end
    checks++;
    if (ones !== 0) begin errors++; $display("FAIL v1_cin_count got %0d want 0", ones); end

    do_op(16'hFFFF, 16'h0001, 1'b0, sum, lat, ones);
    checks++;
    if (sum !== 17'h10000) begin errors++; $display("FAIL v2_sum got %h want 10000", sum); end
    checks++;
    if (ones !== 3) begin errors++; $display("FAIL v2_cin_count got %0d want 3", ones); end

    do_op(16'hFFFF, 16'hFFFF, 1'b1, sum, lat, ones);
    checks++;
    if (sum !== 17'h1FFFF) begin errors++; $display("FAIL v3_sum got %h want 1ffff", sum); end
    checks++;
    if (ones !== 4) begin errors++; $display("FAIL v3_cin_count got %0d want 4", ones); end
    checks++;
    if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL v3_idle_after got %b want 1", bus4.in_ready); end
  endtask

  task automatic test_backpressure();
    int seen;
    seen = 0;
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.in_a      = 16'h0123;
    bus4.in_b      = 16'h0456;
    bus4.in_cin    = 1'b0;
    bus4.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus4.out_valid) begin seen = 1; break; end
    end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL bp_out_valid_timeout got %0d want 1", seen); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus4.out_valid, bus4.in_ready, bus4.out_sum} !== {1'b1, 1'b0, 17'h00579}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%b s=%h want v=1 r=0 s=00579",
                 i, bus4.out_valid, bus4.in_ready, bus4.out_sum);
      end
      @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    checks++;
    if ({bus4.out_valid, bus4.in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", bus4.out_valid, bus4.in_ready);
    end
    checks++;
    if (bus4.out_sum !== 17'h00579) begin errors++; $display("FAIL bp_sum_kept got %h want 00579", bus4.out_sum); end
  endtask

  task automatic test_reset_mid();
    logic [16:0] sum;
    int lat, ones, stray;
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.in_a      = 16'hAAAA;
    bus4.in_b      = 16'h5555;
    bus4.in_cin    = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus4.out_valid); end
    checks++;
    if ({bus4.add_a, bus4.add_b, bus4.add_cin} !== 9'h0) begin
      errors++; $display("FAIL rstmid_adder_inputs got %h want 000", {bus4.add_a, bus4.add_b, bus4.add_cin});
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus4.out_valid) stray++;
    end
    checks++;
    if (stray !== 0 || bus4.in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_no_result got stray=%0d r=%b want stray=0 r=1", stray, bus4.in_ready);
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, sum, lat, ones);
    checks++;
    if (sum !== 17'h01000) begin errors++; $display("FAIL rstmid_next_sum got %h want 01000", sum); end
  endtask

  task automatic test_back_to_back();
    int t, t1, t2;
    int idle_acc;
    t1 = -1;
    t2 = -1;
    idle_acc = 0;
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.in_a      = 16'h8000;
    bus4.in_b      = 16'h8000;
    bus4.in_cin    = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_a   = 16'h1111;
    bus4.in_b   = 16'h2222;
    bus4.in_cin = 1'b1;
    for (t = 1; t < 30; t++) begin
      @(negedge clk);
      if (bus4.in_ready && t1 < 0) idle_acc++;
      if (bus4.out_valid && t1 < 0) begin
        t1 = t;
        checks++;
        if (bus4.out_sum !== 17'h10000) begin errors++; $display("FAIL b2b_first_sum got %h want 10000", bus4.out_sum); end
      end else if (bus4.out_valid && t1 >= 0) begin
        t2 = t;
        checks++;
        if (bus4.out_sum !== 17'h03334) begin errors++; $display("FAIL b2b_second_sum got %h want 03334", bus4.out_sum); end
        break;
      end
    end
    bus4.in_valid = 1'b0;
    checks++;
    if (idle_acc !== 0) begin errors++; $display("FAIL b2b_in_ready_before_first got %0d want 0", idle_acc); end
    checks++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) !== 6) begin
      errors++; $display("FAIL b2b_spacing got t1=%0d t2=%0d want gap 6", t1, t2);
    end
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_nibbles1();
    int lat;
    lat = -1;
    @(negedge clk);
    bus1.in_valid  = 1'b1;
    bus1.in_a      = 4'hF;
    bus1.in_b      = 4'h1;
    bus1.in_cin    = 1'b0;
    bus1.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus1.in_a     = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus1.out_valid) begin lat = i; break; end
    end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL n1_latency got %0d want 1", lat); end
    checks++;
    if (bus1.out_sum !== 5'h10) begin errors++; $display("FAIL n1_sum got %h want 10", bus1.out_sum); end
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    checks++;
    if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL n1_idle got %b want 1", bus1.in_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_nibbles1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
